// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker on the traffic light controller bus.
// Registers light/ON once, decodes the vehicle phase, measures dwell per phase
// and raises sticky flags on illegal codes, bad ordering, short/long phases
// and illegal pedestrian signalling.
module traffic_light_monitor #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MIN_GREEN  = 4,
  parameter int unsigned MIN_YELLOW = 2,
  parameter int unsigned MIN_RED    = 4,
  parameter int unsigned MAX_DWELL  = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       light,
  input  logic             ON,
  input  logic             clr_err,
  output logic [1:0]       phase,
  output logic             phase_valid,
  output logic [CNT_W-1:0] dwell,
  output logic [15:0]      cycles,
  output logic             err_code,
  output logic             err_seq,
  output logic             err_short,
  output logic             err_timeout,
  output logic             err_ped,
  output logic             err_any
);

  localparam int unsigned CYC_W = 16;
  localparam int unsigned ERR_W = 5;
  // flag bit positions inside err_q
  localparam int unsigned E_CODE  = 4;
  localparam int unsigned E_SEQ   = 3;
  localparam int unsigned E_SHORT = 2;
  localparam int unsigned E_TOUT  = 1;
  localparam int unsigned E_PED   = 0;

  localparam logic [1:0] PH_GREEN  = 2'd0;
  localparam logic [1:0] PH_YELLOW = 2'd1;
  localparam logic [1:0] PH_RED    = 2'd2;

  localparam logic [CNT_W-1:0] DWELL_SAT  = '1;
  localparam logic [CNT_W-1:0] DWELL_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'(MAX_DWELL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SYNC  = 2'd1,
    S_TRACK = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [4:0]         light_q;
  logic               on_q;
  logic [ERR_W-1:0]   err_q, err_d, err_set;
  logic [1:0]         phase_d;
  logic               phase_valid_d;
  logic [CNT_W-1:0]   dwell_d;
  logic [CYC_W-1:0]   cycles_d;

  logic               veh_legal;
  logic               ped_legal;
  logic [1:0]         veh_phase;
  logic [1:0]         next_legal;
  logic [CNT_W-1:0]   min_dwell;

  // Decode the registered bus: vehicle one-hot, ped legality, expected successor.
  always_comb begin
    veh_legal  = $onehot(light_q[2:0]);
    veh_phase  = light_q[2] ? PH_RED : (light_q[1] ? PH_YELLOW : PH_GREEN);
    ped_legal  = $onehot(light_q[4:3]) && !(light_q[3] && (light_q[2:0] != 3'b100));
    next_legal = (phase == PH_RED) ? PH_GREEN : (phase + 2'd1);
    case (phase)
      PH_GREEN:  min_dwell = CNT_W'(MIN_GREEN);
      PH_YELLOW: min_dwell = CNT_W'(MIN_YELLOW);
      default:   min_dwell = CNT_W'(MIN_RED);
    endcase
  end

  // Next-state, dwell/cycle bookkeeping and error detection.
  always_comb begin
    state_d       = state;
    phase_d       = phase;
    phase_valid_d = phase_valid;
    dwell_d       = dwell;
    cycles_d      = cycles;
    err_set       = '0;

    case (state)
      S_IDLE: begin
        phase_valid_d = 1'b0;
        dwell_d       = '0;
        state_d       = S_SYNC;
      end
      S_SYNC: begin
        if (!ped_legal) err_set[E_PED] = 1'b1;
        if (veh_legal) begin
          state_d       = S_TRACK;
          phase_d       = veh_phase;
          phase_valid_d = 1'b1;
          dwell_d       = DWELL_ONE;
          if (TIMEOUT_AT == DWELL_ONE) err_set[E_TOUT] = 1'b1;
        end
      end
      S_TRACK: begin
        if (!ped_legal) err_set[E_PED] = 1'b1;
        if (!veh_legal) begin
          // an illegal code drops tracking until a clean code reappears
          err_set[E_CODE] = 1'b1;
          state_d         = S_SYNC;
          phase_valid_d   = 1'b0;
          dwell_d         = '0;
        end else if (veh_phase == phase) begin
          if (dwell != DWELL_SAT) begin
            dwell_d = dwell + DWELL_ONE;
            if (dwell_d == TIMEOUT_AT) err_set[E_TOUT] = 1'b1;
          end
        end else begin
          if (veh_phase != next_legal) err_set[E_SEQ] = 1'b1;
          if (dwell < min_dwell) err_set[E_SHORT] = 1'b1;
          if ((phase == PH_RED) && (veh_phase == PH_GREEN)) cycles_d = cycles + CYC_W'(1);
          phase_d = veh_phase;
          dwell_d = DWELL_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // controller inactive overrides everything: park in IDLE, run no checks
    if (!on_q) begin
      state_d       = S_IDLE;
      phase_valid_d = 1'b0;
      dwell_d       = '0;
      err_set       = '0;
      cycles_d      = cycles;
      phase_d       = phase;
    end

    // a newly detected error wins over a simultaneous clear
    err_d = (err_q & ~{ERR_W{clr_err}}) | err_set;
  end

  // Input stage, state and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      light_q     <= '0;
      on_q        <= 1'b0;
      state       <= S_IDLE;
      phase       <= PH_GREEN;
      phase_valid <= 1'b0;
      dwell       <= '0;
      cycles      <= '0;
      err_q       <= '0;
      err_any     <= 1'b0;
    end else begin
      light_q     <= light;
      on_q        <= ON;
      state       <= state_d;
      phase       <= phase_d;
      phase_valid <= phase_valid_d;
      dwell       <= dwell_d;
      cycles      <= cycles_d;
      err_q       <= err_d;
      err_any     <= |err_d;
    end
  end

  assign err_code    = err_q[E_CODE];
  assign err_seq     = err_q[E_SEQ];
  assign err_short   = err_q[E_SHORT];
  assign err_timeout = err_q[E_TOUT];
  assign err_ped     = err_q[E_PED];

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: table vectors, directed corner sequences and
// random traffic checked against a cycle-level behavioural model.
module tb_traffic_light_monitor;

  localparam logic [4:0] L_G  = 5'b10001;
  localparam logic [4:0] L_Y  = 5'b10010;
  localparam logic [4:0] L_R  = 5'b10100;
  localparam logic [4:0] L_WG = 5'b01001;
  localparam int MAXD = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  light;
  logic        on_i;
  logic        clr_err;
  logic [1:0]  phase;
  logic        phase_valid;
  logic [15:0] dwell;
  logic [15:0] cycles;
  logic        err_code, err_seq, err_short, err_timeout, err_ped, err_any;

  int n_vec = 0;
  int n_mis = 0;

  traffic_light_monitor dut (
    .clk(clk), .rst(rst), .light(light), .ON(on_i), .clr_err(clr_err),
    .phase(phase), .phase_valid(phase_valid), .dwell(dwell), .cycles(cycles),
    .err_code(err_code), .err_seq(err_seq), .err_short(err_short),
    .err_timeout(err_timeout), .err_ped(err_ped), .err_any(err_any)
  );

  always #5 clk = ~clk;

  // behavioural model: mode 0 = off, 1 = searching, 2 = tracking
  int         m_mode = 0, m_ph = 0, m_dw = 0, m_cyc = 0;
  bit         m_valid = 0;
  logic [4:0] m_err = '0;   // {code, seq, short, timeout, ped}
  logic [4:0] m_lq = '0;
  logic       m_on = 1'b0;
  int         min_tab[3] = '{4, 2, 4};

  task automatic model_update();
    logic [4:0] set_f;
    bit vleg, pleg;
    int vph;
    if (!rst) begin
      m_mode = 0; m_ph = 0; m_dw = 0; m_cyc = 0; m_valid = 0;
      m_err = '0; m_lq = '0; m_on = 1'b0;
      return;
    end
    set_f = '0;
    vleg  = ($countones(m_lq[2:0]) == 1);
    vph   = m_lq[2] ? 2 : (m_lq[1] ? 1 : 0);
    pleg  = ($countones(m_lq[4:3]) == 1) && !(m_lq[3] && (m_lq[2:0] != 3'b100));
    if (!m_on) begin
      m_mode = 0; m_valid = 0; m_dw = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else begin
      if (!pleg) set_f[0] = 1'b1;
      if (m_mode == 1) begin
        if (vleg) begin m_mode = 2; m_valid = 1; m_ph = vph; m_dw = 1; end
      end else if (!vleg) begin
        set_f[4] = 1'b1; m_mode = 1; m_valid = 0; m_dw = 0;
      end else if (vph == m_ph) begin
        if (m_dw < 65535) begin
          m_dw++;
          if (m_dw == MAXD) set_f[1] = 1'b1;
        end
      end else begin
        if (vph != (m_ph + 1) % 3) set_f[3] = 1'b1;
        if (m_dw < min_tab[m_ph]) set_f[2] = 1'b1;
        if (m_ph == 2 && vph == 0) m_cyc = (m_cyc + 1) % 65536;
        m_ph = vph; m_dw = 1;
      end
    end
    m_err = (clr_err ? 5'b0 : m_err) | set_f;
    m_lq  = light;
    m_on  = on_i;
  endtask

  function automatic logic [40:0] act_vec();
    return {phase_valid, phase_valid ? phase : 2'b00, dwell, cycles,
            err_code, err_seq, err_short, err_timeout, err_ped, err_any};
  endfunction

  function automatic logic [40:0] model_vec();
    return {m_valid, m_valid ? 2'(m_ph) : 2'b00, 16'(m_dw), 16'(m_cyc), m_err, |m_err};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [4:0] l, input logic o, input logic c);
    rst = r; light = l; on_i = o; clr_err = c;
    @(posedge clk);
    model_update();
    #1;
    check("model", 64'(act_vec()), 64'(model_vec()));
  endtask

  task automatic hold(input logic [4:0] l, input int n);
    repeat (n) step(1'b1, l, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 5'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic       rst;
    logic [4:0] light;
    logic       on;
    logic       clr;
    logic       ev;
    logic [1:0] ep;
    int         ed;
    int         ecyc;
    logic [4:0] eerr;
  } vec_t;

  vec_t tbl[23];

  initial begin
    logic [40:0] ev;
    logic [4:0]  l;
    int cur, len, pick, rises;
    logic prev;

    rst = 1'b0; light = '0; on_i = 1'b0; clr_err = 1'b0;

    // legal G/Y/R/G run, illegal code, clear, ped violation, ON drop
    tbl[0]  = '{1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 2'd0, 0, 0, 5'b00000};
    tbl[1]  = '{1'b1, L_G,      1'b1, 1'b0, 1'b0, 2'd0, 0, 0, 5'b00000};
    tbl[2]  = '{1'b1, L_G,      1'b1, 1'b0, 1'b0, 2'd0, 0, 0, 5'b00000};
    tbl[3]  = '{1'b1, L_G,      1'b1, 1'b0, 1'b1, 2'd0, 1, 0, 5'b00000};
    tbl[4]  = '{1'b1, L_G,      1'b1, 1'b0, 1'b1, 2'd0, 2, 0, 5'b00000};
    tbl[5]  = '{1'b1, L_G,      1'b1, 1'b0, 1'b1, 2'd0, 3, 0, 5'b00000};
    tbl[6]  = '{1'b1, L_G,      1'b1, 1'b0, 1'b1, 2'd0, 4, 0, 5'b00000};
    tbl[7]  = '{1'b1, L_Y,      1'b1, 1'b0, 1'b1, 2'd0, 5, 0, 5'b00000};
    tbl[8]  = '{1'b1, L_Y,      1'b1, 1'b0, 1'b1, 2'd1, 1, 0, 5'b00000};
    tbl[9]  = '{1'b1, L_R,      1'b1, 1'b0, 1'b1, 2'd1, 2, 0, 5'b00000};
    tbl[10] = '{1'b1, L_R,      1'b1, 1'b0, 1'b1, 2'd2, 1, 0, 5'b00000};
    tbl[11] = '{1'b1, L_R,      1'b1, 1'b0, 1'b1, 2'd2, 2, 0, 5'b00000};
    tbl[12] = '{1'b1, L_R,      1'b1, 1'b0, 1'b1, 2'd2, 3, 0, 5'b00000};
    tbl[13] = '{1'b1, L_G,      1'b1, 1'b0, 1'b1, 2'd2, 4, 0, 5'b00000};
    tbl[14] = '{1'b1, L_G,      1'b1, 1'b0, 1'b1, 2'd0, 1, 1, 5'b00000};
    tbl[15] = '{1'b1, 5'b10000, 1'b1, 1'b0, 1'b1, 2'd0, 2, 1, 5'b00000};
    tbl[16] = '{1'b1, L_G,      1'b1, 1'b0, 1'b0, 2'd0, 0, 1, 5'b10000};
    tbl[17] = '{1'b1, L_G,      1'b1, 1'b0, 1'b1, 2'd0, 1, 1, 5'b10000};
    tbl[18] = '{1'b1, L_G,      1'b1, 1'b1, 1'b1, 2'd0, 2, 1, 5'b00000};
    tbl[19] = '{1'b1, L_WG,     1'b1, 1'b0, 1'b1, 2'd0, 3, 1, 5'b00000};
    tbl[20] = '{1'b1, L_G,      1'b1, 1'b0, 1'b1, 2'd0, 4, 1, 5'b00001};
    tbl[21] = '{1'b1, L_G,      1'b0, 1'b0, 1'b1, 2'd0, 5, 1, 5'b00001};
    tbl[22] = '{1'b1, L_G,      1'b0, 1'b0, 1'b0, 2'd0, 0, 1, 5'b00001};

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].rst, tbl[i].light, tbl[i].on, tbl[i].clr);
      ev = {tbl[i].ev, tbl[i].ev ? tbl[i].ep : 2'b00, 16'(tbl[i].ed), 16'(tbl[i].ecyc),
            tbl[i].eerr, |tbl[i].eerr};
      check($sformatf("table[%0d]", i), 64'(act_vec()), 64'(ev));
    end

    // short YELLOW, then clear
    do_reset(); hold(L_G, 8); hold(L_Y, 1); hold(L_R, 3);
    check("short_flags", 64'({err_code, err_seq, err_short, err_timeout, err_ped}), 64'(5'b00100));
    step(1'b1, L_R, 1'b1, 1'b1);
    check("short_clr", 64'(err_any), 64'(0));

    // GREEN straight to RED
    do_reset(); hold(L_G, 8); hold(L_R, 2);
    check("badorder", 64'({err_seq, phase}), 64'({1'b1, 2'd2}));

    // one cycle of 011 inside TRACK, then RED
    do_reset(); hold(L_G, 8);
    step(1'b1, 5'b10011, 1'b1, 1'b0);
    check("code_pre", 64'(phase_valid), 64'(1));
    step(1'b1, L_R, 1'b1, 1'b0);
    check("code_drop", 64'({phase_valid, err_code}), 64'({1'b0, 1'b1}));
    step(1'b1, L_R, 1'b1, 1'b0);
    check("code_resume", 64'({phase_valid, phase, dwell, err_seq}), 64'({1'b1, 2'd2, 16'd1, 1'b0}));

    // WALK with GREEN
    do_reset(); hold(L_G, 4); step(1'b1, L_WG, 1'b1, 1'b0); hold(L_G, 1);
    check("ped_walk_green", 64'(err_ped), 64'(1));

    // reset in the middle of YELLOW after a full cycle
    do_reset(); hold(L_G, 8); hold(L_Y, 3); hold(L_R, 5); hold(L_G, 6); hold(L_Y, 2);
    check("pre_reset_cycles", 64'(cycles), 64'(1));
    step(1'b0, L_Y, 1'b1, 1'b0);
    check("reset_mid", 64'({phase_valid, phase, dwell, cycles, err_any}), 64'(0));

    // ON drop during TRACK keeps flags
    do_reset(); hold(L_G, 8); step(1'b1, L_WG, 1'b1, 1'b0); hold(L_G, 2);
    step(1'b1, L_G, 1'b0, 1'b0); step(1'b1, L_G, 1'b0, 1'b0);
    check("on_drop", 64'({phase_valid, dwell, err_ped}), 64'({1'b0, 16'd0, 1'b1}));

    // long GREEN: single timeout, dwell keeps counting
    do_reset(); rises = 0; prev = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      step(1'b1, L_G, 1'b1, (i == 1050));
      if (err_timeout && !prev) rises++;
      prev = err_timeout;
      if (i == 1001) check("timeout_hit", 64'({err_timeout, dwell}), 64'({1'b1, 16'd1000}));
    end
    check("timeout_once", 64'({rises[7:0], err_timeout, dwell}), 64'({8'd1, 1'b0, 16'd1098}));

    // random traffic against the model
    do_reset(); cur = 0;
    for (int blk = 0; blk < 500; blk++) begin
      len  = $urandom_range(1, 7);
      pick = $urandom_range(0, 99);
      if (pick < 75) cur = (cur + 1) % 3;
      else if (pick < 88) cur = $urandom_range(0, 2);
      l[2:0] = (pick >= 88 && pick < 96) ? 3'($urandom) : 3'(1 << cur);
      l[4:3] = ($urandom_range(0, 19) == 0) ? 2'($urandom) : 2'b10;
      if (cur == 2 && pick < 88 && $urandom_range(0, 3) == 0) l[4:3] = 2'b01;
      for (int k = 0; k < len; k++)
        step($urandom_range(0, 199) != 0, l, $urandom_range(0, 39) != 0, $urandom_range(0, 29) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
